// File: rtl/elevator_pkg.sv
// Shared types and helpers for the SCAN elevator car controller.
package elevator_pkg;

  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN} state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Upper bound on floors the helper can scan; callers zero-extend into it.
  localparam int MAX_FLOORS = 64;

  // Returns {any pending above f, any pending below f}.
  function automatic logic [1:0] pend_dirs(input logic [MAX_FLOORS-1:0] p,
                                           input int f);
    logic [1:0] r;
    r = '0;
    for (int i = 0; i < MAX_FLOORS; i++) begin
      if (p[i] && i > f) r[1] = 1'b1;
      if (p[i] && i < f) r[0] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/elevator_timer.sv
// Loadable down-counter with freeze enable and zero flag; shared by move and door phases.
module elevator_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset)                    count <= '0;
    else if (load)                count <= load_val;
    else if (en && count != '0)   count <= count - W'(1);
  end

  assign zero = (count == '0);

endmodule

// File: rtl/elevator_scheduler.sv
// SCAN elevator car controller: latches floor requests, steps the car, holds the door.
// Optional ESTOP_INPUT_EN adds an estop input that freezes state, timers and floor.
module elevator_scheduler
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS  = 8,
  parameter int MOVE_CYCLES = 16,
  parameter int DOOR_CYCLES = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_FLOORS-1:0]         req,
`ifdef ESTOP_INPUT_EN
  input  logic                          estop,
`endif
  output logic [$clog2(NUM_FLOORS)-1:0] floor,
  output logic                          dir_up,
  output logic                          moving,
  output logic                          door_open,
  output logic                          arrive,
  output logic [NUM_FLOORS-1:0]         pending
);

  localparam int FW   = $clog2(NUM_FLOORS);
  localparam int TMAX = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] MOVE_LD = TW'(MOVE_CYCLES - 1);
  localparam logic [TW-1:0] DOOR_LD = TW'(DOOR_CYCLES - 1);

  state_t              state, state_n;
  logic [FW-1:0]       floor_n, nf;
  logic                dir_n, arrive_n;
  logic [NUM_FLOORS-1:0] pending_n, clr, door_mask;
  logic                t_load, t_en, t_zero, run;
  logic [TW-1:0]       t_val;
  logic [1:0]          dirs;

`ifdef ESTOP_INPUT_EN
  assign run = ~estop;
`else
  assign run = 1'b1;
`endif

  elevator_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (t_load),
    .en       (t_en),
    .load_val (t_val),
    .zero     (t_zero)
  );

  assign dirs = pend_dirs(MAX_FLOORS'(pending), int'(floor));

  always_comb begin
    state_n  = state;
    floor_n  = floor;
    dir_n    = dir_up;
    arrive_n = 1'b0;
    t_load   = 1'b0;
    t_en     = 1'b0;
    t_val    = MOVE_LD;
    clr      = '0;
    nf       = (state == MOVE_UP) ? floor + FW'(1) : floor - FW'(1);
    if (run) begin
      unique case (state)
        IDLE: begin
          if (pending[floor]) begin
            state_n     = DOOR_OPEN;
            t_load      = 1'b1;
            t_val       = DOOR_LD;
            clr[floor]  = 1'b1;
          end else if (dirs[1] && (dir_up || !dirs[0])) begin
            state_n = MOVE_UP;
            dir_n   = DIR_UP;
            t_load  = 1'b1;
          end else if (dirs[0]) begin
            state_n = MOVE_DOWN;
            dir_n   = DIR_DOWN;
            t_load  = 1'b1;
          end
        end
        MOVE_UP, MOVE_DOWN: begin
          if (t_zero) begin
            floor_n  = nf;
            arrive_n = 1'b1;
            t_load   = 1'b1;
            if (pending[nf]) begin
              state_n = DOOR_OPEN;
              t_val   = DOOR_LD;
              clr[nf] = 1'b1;
            end
          end else begin
            t_en = 1'b1;
          end
        end
        DOOR_OPEN: begin
          // A call at the open floor keeps the door open instead of queuing.
          if (req[floor]) begin
            t_load = 1'b1;
            t_val  = DOOR_LD;
          end else if (t_zero) begin
            state_n = IDLE;
          end else begin
            t_en = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign door_mask = (state == DOOR_OPEN) ? (NUM_FLOORS'(1) << floor) : '0;
  assign pending_n = (pending | (req & ~door_mask)) & ~clr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      floor   <= '0;
      dir_up  <= DIR_UP;
      arrive  <= 1'b0;
      pending <= '0;
    end else begin
      assert (!(state == MOVE_UP   && floor == FW'(NUM_FLOORS - 1)) &&
              !(state == MOVE_DOWN && floor == '0));
      state   <= state_n;
      floor   <= floor_n;
      dir_up  <= dir_n;
      arrive  <= arrive_n;
      pending <= pending_n;
    end
  end

  assign moving    = (state == MOVE_UP || state == MOVE_DOWN) && run;
  assign door_open = (state == DOOR_OPEN);

endmodule

// File: doc/elevator_scheduler.md
Name: elevator_scheduler

Overview:
- Multi-floor elevator car controller using SCAN ordering: latches floor requests, chooses travel direction, steps the car one floor at a time, and holds the door open at served floors.
- Generalises the two-floor car to NUM_FLOORS floors, adding travel/door timing and a pending-request register.
- Sits between request buttons (pulses or levels) and car motor/door drivers.

Parameters:
- NUM_FLOORS, 8, number of floors (>=2); floor 0 = ground.
- MOVE_CYCLES, 16, clock cycles to travel one floor (>=1).
- DOOR_CYCLES, 8, clock cycles the door stays open (>=1).
- FW, $clog2(NUM_FLOORS), floor index width (derived, not overridable).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  NUM_FLOORS  request per floor; any cycle high sets that pending bit.
- floor  output  FW  current car floor.
- dir_up  output  1  1 = last/current direction up, 0 = down.
- moving  output  1  high in MOVE_UP/MOVE_DOWN.
- door_open  output  1  high in DOOR_OPEN.
- arrive  output  1  one-cycle pulse on the edge floor changes.
- pending  output  NUM_FLOORS  registered outstanding requests.

Behaviour:
- Reset (sync, active-high): state IDLE, floor=0, dir_up=1, pending=0, timers=0, all outputs 0 except dir_up=1. Reset mid-move or mid-door: aborts immediately; car reports floor 0. Reset has priority over req.
- pending[i] set on the edge after req[i] high. It is cleared on entry to DOOR_OPEN at floor i.
- req for the current floor while DOOR_OPEN is not latched. It reloads the door timer to DOOR_CYCLES.
- States are IDLE, MOVE_UP, MOVE_DOWN and DOOR_OPEN.
- IDLE decision, evaluated on the registered pending value:
  - pending[floor] set -> DOOR_OPEN.
  - Otherwise, requests above and (dir_up or none below) -> MOVE_UP, dir_up=1.
  - Otherwise, requests below -> MOVE_DOWN, dir_up=0.
  - Otherwise stay in IDLE.
  - Transition takes effect on the next edge.
- MOVE_x entry:
  - Move timer loads MOVE_CYCLES-1 and decrements each cycle.
  - When it reaches 0, on that edge: floor +/-1, arrive=1 for one cycle.
  - If pending[new floor] -> DOOR_OPEN.
  - Else continue in the same direction; timer reloads.
- Invariant: the car never moves above NUM_FLOORS-1 or below 0. MOVE_UP is only entered if some pending bit above floor is set, so the top floor is never overshot. An implementation assertion flags any violation.
- Request arriving mid-travel for a floor ahead in the travel direction is served on the way. A request behind the car waits for reversal.
- DOOR_OPEN:
  - Timer loads DOOR_CYCLES-1 and decrements.
  - At 0 -> IDLE; IDLE then re-runs the decision, preferring the retained dir_up.
- Latency, idle car at floor 0 with req[2] pulse at edge t:
  - Edge t+1: pending[2]=1.
  - Edge t+2: MOVE_UP.
  - Edge t+2+MOVE_CYCLES: floor=1.
  - Edge t+2+2*MOVE_CYCLES: floor=2 and DOOR_OPEN.
- Simultaneous requests above and below while IDLE: dir_up decides; tie goes up after reset.

Optional Feature:
- ESTOP_INPUT_EN.
- Defined:
  - Adds input port estop (1 bit).
  - While estop=1: all timers and state freeze, and floor holds. moving=0 and door_open holds its value.
  - pending still latches new requests.
  - On deassert, the move or door timer resumes from its frozen count.
  - reset overrides estop.
- Undefined: no estop port; behaviour exactly as above.

Decomposition:
- Package elevator_pkg holds:
  - state enum (IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN);
  - direction constants DIR_UP=1, DIR_DOWN=0;
  - a helper function computing "any pending above/below floor" masks.
- Sub-module elevator_timer: loadable down-counter with load, enable (freeze) and zero flag. Instantiated twice (move, door) or once shared, since the move and door phases are mutually exclusive.

Test Plan:
All cases use NUM_FLOORS=4, MOVE_CYCLES=4, DOOR_CYCLES=3.
- Reset then idle with req=0 for 20 cycles -> floor=0, state IDLE, moving=0, door_open=0, pending=0.
- req[0] pulse at floor 0 -> door_open high for 3 cycles starting 2 edges later; pending[0] cleared; then IDLE.
- req[3] pulse from floor 0:
  - floor steps 1,2,3 at 4-cycle intervals;
  - arrive pulses 3 times;
  - door_open at floor 3; dir_up=1.
- Car moving up from 0 to 3; req[1] while between 0 and 1, req[0] at the same time:
  - stops at 1 (door), continues to 3 (door);
  - then reverses; dir_up=0; serves floor 0.
- req[2] held high while DOOR_OPEN at floor 2 -> door timer keeps reloading; door stays open until req drops, then closes 3 cycles later; pending[2] stays 0.
- Reset asserted mid-move between floors 1 and 2 -> next edge: floor=0, IDLE, pending=0, arrive=0.
- With ESTOP_INPUT_EN: estop high for 10 cycles mid-move -> floor frozen, moving=0; after release, remaining move count completes normally.
